// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller: Moore FSM driving datapath enables and mux
// selects, with memory-ready stalls, an illegal-opcode trap and a retired-instruction counter.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       OpCode,
    input  logic             Mem_ready,
    output logic             PC_w,
    output logic             PC_w_cond,
    output logic             IorD,
    output logic             Mem_r,
    output logic             Mem_w,
    output logic             IR_w,
    output logic             Mem_to_reg,
    output logic             Reg_w,
    output logic             Reg_dst,
    output logic             ALU_src_A,
    output logic [1:0]       ALU_src_B,
    output logic [1:0]       ALU_op,
    output logic [1:0]       PC_src,
    output logic             Illegal,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] Instr_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             retire_s;
    logic [CNT_W-1:0] count_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; unused encodings fall into TRAP
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_FETCH:     state_nxt_s = Mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (OpCode)
                    OP_LW, OP_SW: state_nxt_s = S_MEM_ADDR;
                    OP_RTYPE:     state_nxt_s = S_EXEC;
                    OP_BEQ:       state_nxt_s = S_BRANCH;
                    OP_J:         state_nxt_s = S_JUMP;
                    OP_ADDI:      state_nxt_s = S_ADDI_EX;
                    default:      state_nxt_s = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                if (OpCode == OP_LW) begin
                    state_nxt_s = S_MEM_READ;
                end else if (OpCode == OP_SW) begin
                    state_nxt_s = S_MEM_WRITE;
                end else begin
                    state_nxt_s = S_TRAP;
                end
            end
            S_MEM_READ:  state_nxt_s = Mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_nxt_s = S_FETCH;
            S_MEM_WRITE: state_nxt_s = Mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC:      state_nxt_s = S_R_WB;
            S_R_WB:      state_nxt_s = S_FETCH;
            S_BRANCH:    state_nxt_s = S_FETCH;
            S_JUMP:      state_nxt_s = S_FETCH;
            S_ADDI_EX:   state_nxt_s = S_ADDI_WB;
            S_ADDI_WB:   state_nxt_s = S_FETCH;
            S_TRAP:      state_nxt_s = S_TRAP;
            default:     state_nxt_s = S_TRAP;
        endcase
    end

    // An instruction retires when a completing state hands back to FETCH
    always_comb begin
        retire_s = 1'b0;
        if (state_nxt_s == S_FETCH) begin
            case (state_r)
                S_MEM_WB, S_MEM_WRITE, S_R_WB,
                S_BRANCH, S_JUMP, S_ADDI_WB: retire_s = 1'b1;
                default:                     retire_s = 1'b0;
            endcase
        end else begin
            retire_s = 1'b0;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign State       = state_r;
    assign Instr_count = count_r;

    // Moore output decode, forced quiet while reset is held so nothing commits mid-reset
    always_comb begin
        PC_w       = 1'b0;
        PC_w_cond  = 1'b0;
        IorD       = 1'b0;
        Mem_r      = 1'b0;
        Mem_w      = 1'b0;
        IR_w       = 1'b0;
        Mem_to_reg = 1'b0;
        Reg_w      = 1'b0;
        Reg_dst    = 1'b0;
        ALU_src_A  = 1'b0;
        ALU_src_B  = 2'b00;
        ALU_op     = 2'b00;
        PC_src     = 2'b00;
        Illegal    = 1'b0;
        if (rst_n) begin
            case (state_r)
                S_FETCH: begin
                    Mem_r     = 1'b1;
                    ALU_src_B = 2'b01;
                    IR_w      = Mem_ready;
                    PC_w      = Mem_ready;
                end
                S_DECODE: ALU_src_B = 2'b11;
                S_MEM_ADDR, S_ADDI_EX: begin
                    ALU_src_A = 1'b1;
                    ALU_src_B = 2'b10;
                end
                S_MEM_READ: begin
                    Mem_r = 1'b1;
                    IorD  = 1'b1;
                end
                S_MEM_WB: begin
                    Reg_w      = 1'b1;
                    Mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    Mem_w = 1'b1;
                    IorD  = 1'b1;
                end
                S_EXEC: begin
                    ALU_src_A = 1'b1;
                    ALU_op    = 2'b10;
                end
                S_R_WB: begin
                    Reg_w   = 1'b1;
                    Reg_dst = 1'b1;
                end
                S_BRANCH: begin
                    ALU_src_A = 1'b1;
                    ALU_op    = 2'b01;
                    PC_w_cond = 1'b1;
                    PC_src    = 2'b01;
                end
                S_JUMP: begin
                    PC_w   = 1'b1;
                    PC_src = 2'b10;
                end
                S_ADDI_WB: Reg_w = 1'b1;
                S_TRAP:    Illegal = 1'b1;
                default:   Illegal = 1'b0;
            endcase
        end else begin
            Illegal = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a driver applies directed per-cycle vectors and
// queues hand-computed expectations; a monitor pops and compares on every falling edge.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [5:0]  OpCode;
    logic        Mem_ready;
    logic        PC_w, PC_w_cond, IorD, Mem_r, Mem_w, IR_w, Mem_to_reg, Reg_w, Reg_dst, ALU_src_A;
    logic [1:0]  ALU_src_B, ALU_op, PC_src;
    logic        Illegal;
    logic [3:0]  State;
    logic [31:0] Instr_count;

    // Narrow-counter instance sharing the same stimulus, used to observe wrap-around
    logic        n_PC_w, n_PC_w_cond, n_IorD, n_Mem_r, n_Mem_w, n_IR_w, n_Mem_to_reg, n_Reg_w;
    logic        n_Reg_dst, n_ALU_src_A, n_Illegal;
    logic [1:0]  n_ALU_src_B, n_ALU_op, n_PC_src;
    logic [3:0]  n_State;
    logic [1:0]  n_Instr_count;

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Mem_ready(Mem_ready),
        .PC_w(PC_w), .PC_w_cond(PC_w_cond), .IorD(IorD), .Mem_r(Mem_r), .Mem_w(Mem_w),
        .IR_w(IR_w), .Mem_to_reg(Mem_to_reg), .Reg_w(Reg_w), .Reg_dst(Reg_dst),
        .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B), .ALU_op(ALU_op), .PC_src(PC_src),
        .Illegal(Illegal), .State(State), .Instr_count(Instr_count)
    );

    multicycle_control #(.CNT_W(2)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Mem_ready(Mem_ready),
        .PC_w(n_PC_w), .PC_w_cond(n_PC_w_cond), .IorD(n_IorD), .Mem_r(n_Mem_r), .Mem_w(n_Mem_w),
        .IR_w(n_IR_w), .Mem_to_reg(n_Mem_to_reg), .Reg_w(n_Reg_w), .Reg_dst(n_Reg_dst),
        .ALU_src_A(n_ALU_src_A), .ALU_src_B(n_ALU_src_B), .ALU_op(n_ALU_op), .PC_src(n_PC_src),
        .Illegal(n_Illegal), .State(n_State), .Instr_count(n_Instr_count)
    );

    // {PC_w,PC_w_cond,IorD,Mem_r,Mem_w,IR_w,Mem_to_reg,Reg_w,Reg_dst,ALU_src_A,ALU_src_B,ALU_op,PC_src,Illegal}
    localparam logic [16:0] C_RESET  = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_FRDY   = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FWAIT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DEC    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_MADDR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MRD    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MWB    = 17'b0_0_0_0_0_0_1_1_0_0_00_00_00_0;
    localparam logic [16:0] C_MWR    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_AWB    = 17'b0_0_0_0_0_0_0_1_0_0_00_00_00_0;
    localparam logic [16:0] C_TRAP   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctrl;
        logic [31:0] cnt;
    } exp_t;

    exp_t  exp_q[$];
    int    vectors;
    int    miscompares;
    logic [16:0] act_ctrl;

    assign act_ctrl = {PC_w, PC_w_cond, IorD, Mem_r, Mem_w, IR_w, Mem_to_reg, Reg_w, Reg_dst,
                       ALU_src_A, ALU_src_B, ALU_op, PC_src, Illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors left", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Monitor: one expectation per cycle, checked mid-cycle away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (State !== e.st) begin
                    miscompares++;
                    $display("FAIL state vec %0d: got %0d want %0d", vectors, State, e.st);
                end
                if (act_ctrl !== e.ctrl) begin
                    miscompares++;
                    $display("FAIL ctrl vec %0d (state %0d): got %b want %b", vectors, State, act_ctrl, e.ctrl);
                end
                if (Instr_count !== e.cnt) begin
                    miscompares++;
                    $display("FAIL count vec %0d: got %0d want %0d", vectors, Instr_count, e.cnt);
                end
                if (n_Instr_count !== e.cnt[1:0]) begin
                    miscompares++;
                    $display("FAIL wrap_count vec %0d: got %0d want %0d", vectors, n_Instr_count, e.cnt[1:0]);
                end
            end
        end
    end

    task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input logic [16:0] c, input logic [31:0] n);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = r;
        OpCode    = op;
        Mem_ready = rdy;
        e.st   = st;
        e.ctrl = c;
        e.cnt  = n;
        exp_q.push_back(e);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        OpCode      = 6'h00;
        Mem_ready   = 1'b0;

        step(1'b0, 6'h23, 1'b1, 4'd0, C_RESET, 32'd0);
        // lw, no stalls: 0,1,2,3,4
        step(1'b1, 6'h23, 1'b1, 4'd0, C_FRDY,  32'd0);
        step(1'b1, 6'h23, 1'b1, 4'd1, C_DEC,   32'd0);
        step(1'b1, 6'h23, 1'b1, 4'd2, C_MADDR, 32'd0);
        step(1'b1, 6'h23, 1'b1, 4'd3, C_MRD,   32'd0);
        step(1'b1, 6'h23, 1'b1, 4'd4, C_MWB,   32'd0);
        // R-type
        step(1'b1, 6'h00, 1'b1, 4'd0, C_FRDY,  32'd1);
        step(1'b1, 6'h00, 1'b1, 4'd1, C_DEC,   32'd1);
        step(1'b1, 6'h00, 1'b1, 4'd6, C_EXEC,  32'd1);
        step(1'b1, 6'h00, 1'b1, 4'd7, C_RWB,   32'd1);
        // beq
        step(1'b1, 6'h04, 1'b1, 4'd0, C_FRDY,  32'd2);
        step(1'b1, 6'h04, 1'b1, 4'd1, C_DEC,   32'd2);
        step(1'b1, 6'h04, 1'b1, 4'd8, C_BRANCH,32'd2);
        // addi: fourth retirement wraps the 2-bit counter to 0
        step(1'b1, 6'h08, 1'b1, 4'd0, C_FRDY,  32'd3);
        step(1'b1, 6'h08, 1'b1, 4'd1, C_DEC,   32'd3);
        step(1'b1, 6'h08, 1'b1, 4'd10, C_MADDR,32'd3);
        step(1'b1, 6'h08, 1'b1, 4'd11, C_AWB,  32'd3);
        // j
        step(1'b1, 6'h02, 1'b1, 4'd0, C_FRDY,  32'd4);
        step(1'b1, 6'h02, 1'b1, 4'd1, C_DEC,   32'd4);
        step(1'b1, 6'h02, 1'b1, 4'd9, C_JUMP,  32'd4);
        // sw: 3 fetch stalls, Mem_ready ignored in DECODE/MEM_ADDR, 2 write stalls
        step(1'b1, 6'h2B, 1'b0, 4'd0, C_FWAIT, 32'd5);
        step(1'b1, 6'h2B, 1'b0, 4'd0, C_FWAIT, 32'd5);
        step(1'b1, 6'h2B, 1'b0, 4'd0, C_FWAIT, 32'd5);
        step(1'b1, 6'h2B, 1'b1, 4'd0, C_FRDY,  32'd5);
        step(1'b1, 6'h2B, 1'b0, 4'd1, C_DEC,   32'd5);
        step(1'b1, 6'h2B, 1'b0, 4'd2, C_MADDR, 32'd5);
        step(1'b1, 6'h2B, 1'b0, 4'd5, C_MWR,   32'd5);
        step(1'b1, 6'h2B, 1'b0, 4'd5, C_MWR,   32'd5);
        step(1'b1, 6'h2B, 1'b1, 4'd5, C_MWR,   32'd5);
        // sw interrupted by reset while in MEM_WRITE
        step(1'b1, 6'h2B, 1'b1, 4'd0, C_FRDY,  32'd6);
        step(1'b1, 6'h2B, 1'b1, 4'd1, C_DEC,   32'd6);
        step(1'b1, 6'h2B, 1'b1, 4'd2, C_MADDR, 32'd6);
        step(1'b1, 6'h2B, 1'b0, 4'd5, C_MWR,   32'd6);
        step(1'b0, 6'h2B, 1'b1, 4'd0, C_RESET, 32'd0);
        // normal fetch resumes: j
        step(1'b1, 6'h02, 1'b1, 4'd0, C_FRDY,  32'd0);
        step(1'b1, 6'h02, 1'b1, 4'd1, C_DEC,   32'd0);
        step(1'b1, 6'h02, 1'b1, 4'd9, C_JUMP,  32'd0);
        // illegal opcode traps and sticks
        step(1'b1, 6'h3F, 1'b1, 4'd0, C_FRDY,  32'd1);
        step(1'b1, 6'h3F, 1'b1, 4'd1, C_DEC,   32'd1);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, (i < 6) ? 6'h3F : 6'h23, i[0], 4'd12, C_TRAP, 32'd1);
        end
        // reset clears the trap
        step(1'b0, 6'h00, 1'b1, 4'd0, C_RESET, 32'd0);
        step(1'b1, 6'h00, 1'b0, 4'd0, C_FWAIT, 32'd0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending vectors want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the MIPS datapath: a Moore-style FSM that splits each instruction into fetch, decode, execute, memory and write-back steps over a shared ALU and a single unified memory port. Supported opcodes are R-type (0x00), lw (0x23), sw (0x2B), beq (0x04), j (0x02) and addi (0x08). It drives every datapath mux and write-enable, stalls on a memory-ready handshake, traps on illegal opcodes and counts retired instructions.

## Interface
- CNT_W, 32, width of the retired-instruction counter.

- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- OpCode  in  6  instruction bits [31:26] from the instruction register.
- Mem_ready  in  1  memory completes the current access this cycle.
- PC_w, PC_w_cond, IorD, Mem_r, Mem_w, IR_w, Mem_to_reg, Reg_w, Reg_dst, ALU_src_A  out  1 each  datapath enables and mux selects.
- ALU_src_B  out  2  00 Rt, 01 constant 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- ALU_op  out  2  00 add, 01 subtract, 10 decode funct.
- PC_src  out  2  00 ALU result, 01 ALUOut register, 10 jump target.
- Illegal  out  1  high while in TRAP.
- State  out  4  current state encoding, for debug.
- Instr_count  out  CNT_W  retired-instruction count.

## Operation
- Outputs decode from the registered state. Any output not listed for a state is 0.
- FETCH (0): Mem_r=1, IorD=0, ALU_src_A=0, ALU_src_B=01, ALU_op=00, PC_src=00. IR_w=PC_w=Mem_ready. Go to DECODE when Mem_ready=1, else hold.
- DECODE (1): ALU_src_A=0, ALU_src_B=11, ALU_op=00.
  - lw or sw → MEM_ADDR.
  - 0x00 → EXEC.
  - beq → BRANCH.
  - j → JUMP.
  - addi → ADDI_EX.
  - any other opcode → TRAP.
- MEM_ADDR (2): ALU_src_A=1, ALU_src_B=10, ALU_op=00. lw → MEM_READ; sw → MEM_WRITE.
- MEM_READ (3): Mem_r=1, IorD=1. Go to MEM_WB on Mem_ready, else hold.
- MEM_WB (4): Reg_w=1, Reg_dst=0, Mem_to_reg=1 → FETCH.
- MEM_WRITE (5): Mem_w=1, IorD=1. Go to FETCH on Mem_ready, else hold.
- EXEC (6): ALU_src_A=1, ALU_src_B=00, ALU_op=10 → R_WB.
- R_WB (7): Reg_w=1, Reg_dst=1, Mem_to_reg=0 → FETCH.
- BRANCH (8): ALU_src_A=1, ALU_src_B=00, ALU_op=01, PC_w_cond=1, PC_src=01 → FETCH.
- JUMP (9): PC_w=1, PC_src=10 → FETCH.
- ADDI_EX (10): ALU_src_A=1, ALU_src_B=10, ALU_op=00 → ADDI_WB.
- ADDI_WB (11): Reg_w=1, Reg_dst=0, Mem_to_reg=0 → FETCH.
- TRAP (12): Illegal=1. All write enables are 0. The FSM stays in TRAP until reset.
- Encodings 13–15 are unreachable. If entered, go to TRAP.
- Instr_count increments by 1 on every transition into FETCH from MEM_WB, MEM_WRITE, R_WB, BRANCH, JUMP or ADDI_WB.
  - It wraps modulo 2^CNT_W.
  - It is unchanged in TRAP and during stalls.

## Timing
- Reset: rst_n=0 immediately forces State=0 (FETCH) and Instr_count=0. While rst_n=0, all control outputs are 0 and Illegal=0.
- First fetch: after rst_n deasserts, the first rising edge with Mem_ready=1 in FETCH loads IR and PC.
- Latency with zero wait states:
  - lw: 5 cycles.
  - sw, R-type, addi: 4 cycles.
  - beq, j: 3 cycles.
- Each Mem_ready=0 cycle in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle. Outputs stay constant during the stall.
- OpCode is sampled only in DECODE and MEM_ADDR. The IR holds it stable, since IR_w=0 outside FETCH.
- Mem_ready is ignored in states with no memory access.
- Reset asserted mid-instruction: no further enables are issued. No partial write is committed after the reset edge.

## Test plan
- Reset, then lw with Mem_ready=1 always → State sequence 0,1,2,3,4,0. Reg_w=Mem_to_reg=1 only in state 4. Instr_count=1.
- R-type then beq then j, no stalls → 4+3+3 cycles. PC_w_cond=1 only in BRANCH with PC_src=01. PC_w=1 in JUMP with PC_src=10. Instr_count=3.
- sw with Mem_ready low for 3 cycles in FETCH and 2 cycles in MEM_WRITE → 9 cycles total. IR_w pulses exactly once. Mem_w is held high for 3 cycles.
- OpCode=0x3F in DECODE → TRAP next cycle. Illegal=1, all enables 0, State stuck at 12 for 10+ cycles. Instr_count unchanged.
- Reset asserted during MEM_WRITE → same-cycle Mem_w=0 and State=0. After release, normal fetch resumes.
- Preload Instr_count to 2^CNT_W−1 via forced state, then retire addi → Instr_count=0.
